// File: rtl/imm_extend_pipe.sv
// ============================================================================
// Module   : imm_extend_pipe
// Brief    : Pipelined immediate/operand extension unit with a registered
//            output stage and a one-entry skid buffer (valid/ready on both
//            sides, in_ready fully registered).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_extend_pipe #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic [2:0]           in_mode,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 mode_err,
    input  logic                 err_clr
);

    localparam logic [2:0] MODE_SIGN   = 3'b000;
    localparam logic [2:0] MODE_ZERO   = 3'b001;
    localparam logic [2:0] MODE_UPPER  = 3'b010;
    localparam logic [2:0] MODE_BSIGN  = 3'b011;
    localparam logic [2:0] MODE_BZERO  = 3'b100;
    localparam logic [2:0] MODE_BRANCH = 3'b101;

    // Output register (OR) and skid register (SK) state.
    logic                 or_valid_q, or_valid_d;
    logic [OUT_WIDTH-1:0] or_data_q,  or_data_d;
    logic [TAG_WIDTH-1:0] or_tag_q,   or_tag_d;
    logic                 sk_valid_q, sk_valid_d;
    logic [OUT_WIDTH-1:0] sk_data_q,  sk_data_d;
    logic [TAG_WIDTH-1:0] sk_tag_q,   sk_tag_d;
    logic                 in_ready_q, in_ready_d;
    logic                 mode_err_q, mode_err_d;

    logic                 w_accept;
    logic                 w_drain;
    logic                 w_or_free;
    logic                 w_illegal;
    logic [OUT_WIDTH-1:0] w_sext;
    logic [OUT_WIDTH-1:0] w_ext;

    assign w_accept  = in_valid && in_ready_q;
    assign w_drain   = or_valid_q && out_ready;
    assign w_or_free = !or_valid_q || w_drain;
    assign w_illegal = in_mode[2] && in_mode[1];

    // Full-width sign extension is shared by sign and branch modes.
    assign w_sext = {{(OUT_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};

    // Extension happens before storage so both OR and SK hold final results.
    always_comb begin
        w_ext = '0;
        case (in_mode)
            MODE_SIGN:   w_ext = w_sext;
            MODE_ZERO:   w_ext = {{(OUT_WIDTH-IN_WIDTH){1'b0}}, in_data};
            MODE_UPPER:  w_ext = {in_data, {(OUT_WIDTH-IN_WIDTH){1'b0}}};
            MODE_BSIGN:  w_ext = {{(OUT_WIDTH-8){in_data[7]}}, in_data[7:0]};
            MODE_BZERO:  w_ext = {{(OUT_WIDTH-8){1'b0}}, in_data[7:0]};
            MODE_BRANCH: w_ext = {w_sext[OUT_WIDTH-3:0], 2'b00};
            default:     w_ext = '0;
        endcase
    end

    // Next-state for OR/SK: SK always refills OR first to keep FIFO order.
    always_comb begin
        or_valid_d = or_valid_q && !w_drain;
        or_data_d  = or_data_q;
        or_tag_d   = or_tag_q;
        sk_valid_d = sk_valid_q;
        sk_data_d  = sk_data_q;
        sk_tag_d   = sk_tag_q;
        if (w_or_free) begin
            if (sk_valid_q) begin
                or_valid_d = 1'b1;
                or_data_d  = sk_data_q;
                or_tag_d   = sk_tag_q;
                sk_valid_d = w_accept;
                if (w_accept) begin
                    sk_data_d = w_ext;
                    sk_tag_d  = in_tag;
                end
            end else if (w_accept) begin
                or_valid_d = 1'b1;
                or_data_d  = w_ext;
                or_tag_d   = in_tag;
            end
        end else if (w_accept) begin
            sk_valid_d = 1'b1;
            sk_data_d  = w_ext;
            sk_tag_d   = in_tag;
        end
        // Registered ready: accept next cycle only while the skid slot is free.
        in_ready_d = !sk_valid_d;
    end

    // Sticky illegal-mode flag; a new error wins over a simultaneous clear.
    always_comb begin
        mode_err_d = mode_err_q;
        if (w_accept && w_illegal) begin
            mode_err_d = 1'b1;
        end else if (err_clr) begin
            mode_err_d = 1'b0;
        end
    end

    // State registers; reset flushes all buffered transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_valid_q <= 1'b0;
            or_data_q  <= '0;
            or_tag_q   <= '0;
            sk_valid_q <= 1'b0;
            sk_data_q  <= '0;
            sk_tag_q   <= '0;
            in_ready_q <= 1'b0;
            mode_err_q <= 1'b0;
        end else begin
            or_valid_q <= or_valid_d;
            or_data_q  <= or_data_d;
            or_tag_q   <= or_tag_d;
            sk_valid_q <= sk_valid_d;
            sk_data_q  <= sk_data_d;
            sk_tag_q   <= sk_tag_d;
            in_ready_q <= in_ready_d;
            mode_err_q <= mode_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = or_valid_q;
    assign out_data  = or_data_q;
    assign out_tag   = or_tag_q;
    assign mode_err  = mode_err_q;

endmodule

`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
// ============================================================================
// Module   : tb_imm_extend_pipe
// Brief    : Self-checking bench for imm_extend_pipe: directed cases plus
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_extend_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [2:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        mode_err;
    logic        err_clr;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_in_data;
    logic [2:0]  s_in_mode;
    logic [4:0]  s_in_tag;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [15:0] s_out_data;
    logic [4:0]  s_out_tag;
    logic        s_mode_err;

    int total;
    int bad;

    // Reference model state: FIFO of pending results, ready and error flag.
    logic [31:0] q_data[$];
    logic [4:0]  q_tag[$];
    logic        rdy_m;
    logic        err_m;
    int          n_out;

    imm_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32), .TAG_WIDTH(5)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .mode_err(mode_err), .err_clr(err_clr)
    );

    imm_extend_pipe #(.IN_WIDTH(8), .OUT_WIDTH(16), .TAG_WIDTH(5)) u_small (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .in_mode(s_in_mode), .in_tag(s_in_tag),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_tag(s_out_tag), .mode_err(s_mode_err), .err_clr(1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Extension rules expressed as integer arithmetic on the field value.
    function automatic logic [63:0] ref_ext(input logic [63:0] d, input int md, input int iw, input int ow);
        longint          s;
        longint          b;
        longint unsigned m;
        m = (64'd1 << ow) - 64'd1;
        s = (d >= (64'd1 << (iw - 1))) ? longint'(d) - longint'(64'd1 << iw) : longint'(d);
        b = longint'(d % 256);
        if (b >= 128) b = b - 256;
        case (md)
            0:       return 64'(s) & m;
            1:       return d & m;
            2:       return (d << (ow - iw)) & m;
            3:       return 64'(b) & m;
            4:       return (d % 256) & m;
            5:       return 64'(s * 4) & m;
            default: return 64'd0;
        endcase
    endfunction

    // One clock: check outputs against the model mid-cycle, then advance it.
    task automatic step();
        logic acc;
        logic drn;
        @(negedge clk);
        check_val("in_ready", 64'(in_ready), 64'(rdy_m));
        check_val("out_valid", 64'(out_valid), 64'(q_data.size() > 0));
        if (q_data.size() > 0) begin
            check_val("out_data", 64'(out_data), 64'(q_data[0]));
            check_val("out_tag", 64'(out_tag), 64'(q_tag[0]));
        end
        check_val("mode_err", 64'(mode_err), 64'(err_m));
        acc = in_valid && rdy_m;
        drn = (q_data.size() > 0) && out_ready;
        @(posedge clk);
        if (drn) begin
            void'(q_data.pop_front());
            void'(q_tag.pop_front());
            n_out++;
        end
        if (acc) begin
            q_data.push_back(32'(ref_ext(64'(in_data), int'(in_mode), 16, 32)));
            q_tag.push_back(in_tag);
        end
        if (acc && in_mode >= 3'd6) err_m = 1'b1;
        else if (err_clr) err_m = 1'b0;
        rdy_m = (q_data.size() < 2);
        #1;
    endtask

    // Send one transaction with the consumer ready and check the literal result.
    task automatic one(input string tag, input logic [15:0] d, input logic [2:0] md, input logic [31:0] exp);
        in_valid  = 1'b1;
        in_data   = d;
        in_mode   = md;
        in_tag    = 5'(md) + 5'd7;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check_val(tag, 64'(out_data), 64'(exp));
        step();
    endtask

    initial begin
        int n0;
        total = 0; bad = 0; n_out = 0;
        rdy_m = 1'b0; err_m = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_mode = '0; in_tag = '0;
        out_ready = 1'b0; err_clr = 1'b0;
        s_in_valid = 1'b0; s_in_data = '0; s_in_mode = '0; s_in_tag = '0;
        s_out_ready = 1'b1;

        #12;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_data", 64'(out_data), 64'd0);
        check_val("rst_out_tag", 64'(out_tag), 64'd0);
        check_val("rst_mode_err", 64'(mode_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rdy_m = 1'b1;
        check_val("rel_in_ready", 64'(in_ready), 64'd1);

        // Directed extension cases.
        one("sign_8001", 16'h8001, 3'd0, 32'hFFFF8001);
        one("sign_7fff", 16'h7FFF, 3'd0, 32'h00007FFF);
        one("zero",      16'h80F0, 3'd1, 32'h000080F0);
        one("upper",     16'h80F0, 3'd2, 32'h80F00000);
        one("bsign",     16'h80F0, 3'd3, 32'hFFFFFFF0);
        one("bzero",     16'h80F0, 3'd4, 32'h000000F0);
        one("branch",    16'h80F0, 3'd5, 32'hFFFE03C0);
        one("illegal",   16'h80F0, 3'd6, 32'h00000000);
        check_val("err_set", 64'(mode_err), 64'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_val("err_clr", 64'(mode_err), 64'd0);

        // Back-pressure: two accepts fill OR and SK, third waits.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 3'd0;
        in_data   = 16'h0011; in_tag = 5'd1; step();
        in_data   = 16'h0022; in_tag = 5'd2; step();
        check_val("bp_ready_low", 64'(in_ready), 64'd0);
        in_data   = 16'h0033; in_tag = 5'd3; step();
        check_val("bp_head_tag", 64'(out_tag), 64'd1);
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        step();
        step();

        // Full throughput: 20 back-to-back transfers.
        n0 = n_out;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 16'(i * 1311 + 5);
            in_mode = 3'($urandom_range(0, 5));
            in_tag  = 5'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        check_val("thru_count", 64'(n_out - n0), 64'd20);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            err_clr   = ($urandom_range(0, 9) == 0);
            in_data   = 16'($urandom);
            in_mode   = 3'($urandom_range(0, 7));
            in_tag    = 5'($urandom);
            step();
        end
        in_valid = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
        step(); step(); step();

        // Mid-operation reset with OR and SK full and the error flag set.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode = 3'd6; in_data = 16'h1234; in_tag = 5'd9; step();
        in_mode = 3'd0; in_data = 16'h4321; in_tag = 5'd10; step();
        in_valid = 1'b0;
        check_val("pre_rst_full", 64'(in_ready), 64'd0);
        check_val("pre_rst_err", 64'(mode_err), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_val("mid_rst_mode_err", 64'(mode_err), 64'd0);
        q_data.delete();
        q_tag.delete();
        err_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rdy_m = 1'b1;
        check_val("post_rst_ready", 64'(in_ready), 64'd1);
        one("post_rst_data", 16'hFF00, 3'd0, 32'hFFFFFF00);

        // Narrow instance: 8 -> 16.
        s_in_valid = 1'b1; s_in_data = 8'h80; s_in_mode = 3'd0; s_in_tag = 5'd4;
        @(posedge clk); #1;
        check_val("small_sign", 64'(s_out_data), 64'h0000_0000_0000_FF80);
        check_val("small_sign_model", 64'(s_out_data), ref_ext(64'h80, 0, 8, 16));
        s_in_mode = 3'd2;
        @(posedge clk); #1;
        check_val("small_upper", 64'(s_out_data), 64'h0000_0000_0000_8000);
        check_val("small_tag", 64'(s_out_tag), 64'd4);
        s_in_valid = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
